// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencing controller:
// FSM state encoding and the word-address width used for PC targets.
package if_fetch_ctrl_pkg;

    localparam int ADDR_W = 30;

    typedef logic [ADDR_W-1:0] word_addr_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        PEND = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_ctrl_stall_timer.sv
// Consecutive-stall counter for the fetch controller: saturates at MAX_STALL
// and latches a sticky timeout flag that only reset clears.
module if_fetch_ctrl_stall_timer #(
    parameter int MAX_STALL = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_cycle,
    output logic stall_timeout
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_STALL);

    logic [7:0] stall_cnt;
    logic [7:0] cnt_next;

    // Any cycle that is not a stall ends the run and restarts the count.
    always_comb begin
        cnt_next = '0;
        if (stall_cycle) begin
            cnt_next = (stall_cnt == MAX_CNT) ? MAX_CNT : stall_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
        end else begin
            stall_cnt <= cnt_next;
            if (stall_cycle && (cnt_next == MAX_CNT)) begin
                stall_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencing controller: PC hold/advance/redirect, pipeline
// flushes, boot hold-off and stall watchdog. Optional macro:
// IF_FETCH_CTRL_PERF_CNT_EN adds redirect and stall-cycle performance counters.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int MAX_STALL   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_use_stall,
    input  logic        mem_busy,
    input  logic        id_jump,
    input  word_addr_t  id_jump_target,
    input  logic        ex_branch,
    input  word_addr_t  ex_branch_target,
    output logic        pc_stall,
    output logic        pc_src,
    output word_addr_t  target_pc_addr,
`ifdef IF_FETCH_CTRL_PERF_CNT_EN
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_stall_cycles,
`endif
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        stall_timeout
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    fetch_state_e state;
    fetch_state_e state_next;
    logic [3:0]   boot_cnt;
    word_addr_t   pend_target;
    word_addr_t   sel_target;
    logic         stall_req;
    logic         redirect;
    logic         stall_cycle;

    assign stall_req = load_use_stall | mem_busy;
    assign redirect  = ex_branch | id_jump;
    // EX holds the older instruction, so its branch wins over an ID jump.
    assign sel_target = ex_branch ? ex_branch_target : id_jump_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            boot_cnt    <= '0;
            pend_target <= '0;
        end else begin
            state <= state_next;
            if (state == BOOT) begin
                boot_cnt <= boot_cnt + 4'd1;
            end
            if ((state == RUN) && redirect && stall_req) begin
                pend_target <= sel_target;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT: begin
                if (boot_cnt == BOOT_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stall_req) begin
                    state_next = redirect ? PEND : HOLD;
                end
            end
            HOLD, PEND: begin
                if (!stall_req) begin
                    state_next = RUN;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    // While frozen (HOLD/PEND) the younger stages are squashed or stalled,
    // so their redirect inputs carry nothing valid and are not looked at.
    always_comb begin
        pc_stall       = 1'b0;
        pc_src         = 1'b0;
        target_pc_addr = '0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        case (state)
            BOOT: begin
                pc_stall = 1'b1;
            end
            RUN: begin
                pc_stall       = stall_req;
                pc_src         = redirect & ~stall_req;
                target_pc_addr = sel_target;
                if_id_flush    = redirect;
                id_ex_flush    = ex_branch;
            end
            HOLD: begin
                pc_stall = stall_req;
            end
            PEND: begin
                pc_stall       = stall_req;
                pc_src         = ~stall_req;
                target_pc_addr = pend_target;
            end
            default: begin
                pc_stall = 1'b1;
            end
        endcase
    end

    assign stall_cycle = pc_stall & (state != BOOT);

    if_fetch_ctrl_stall_timer #(
        .MAX_STALL (MAX_STALL)
    ) u_stall_timer (
        .clk           (clk),
        .rst           (rst),
        .stall_cycle   (stall_cycle),
        .stall_timeout (stall_timeout)
    );

`ifdef IF_FETCH_CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_redirects    <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (pc_src) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
            if (stall_cycle) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Sequencing controller for the pipeline instruction-fetch unit.
- Decides each cycle whether the PC holds, advances by +4, or loads a branch/jump target, and raises IF/ID and ID/EX flushes.
- Arbitrates redirect requests from ID (jumps) and EX (branches) against stall requests from the hazard unit and data memory.
- Buffers a redirect that arrives while the PC is frozen, holds fetch off for a boot interval after reset, and flags runaway stalls.

Parameters:
- BOOT_CYCLES, 2, cycles fetch is held after reset release (legal range 1..15).
- MAX_STALL, 255, consecutive stall cycles before stall_timeout is raised (legal range 1..255).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- load_use_stall  in  1  hazard unit requests a PC/IF hold
- mem_busy  in  1  data memory not ready; PC hold
- id_jump  in  1  jump or jr resolved in ID
- id_jump_target  in  30  word address [31:2] for the jump
- ex_branch  in  1  taken branch resolved in EX
- ex_branch_target  in  30  word address [31:2] for the branch
- pc_stall  out  1  to the fetch unit's stall input
- pc_src  out  1  1 = load target_pc_addr, 0 = PC+4
- target_pc_addr  out  30  redirect word address
- if_id_flush  out  1  squash the IF/ID register
- id_ex_flush  out  1  squash the ID/EX register
- stall_timeout  out  1  sticky; stall run reached MAX_STALL

Behaviour:
- Definition: stall_req = load_use_stall | mem_busy.
- Outputs are combinational from state, registers and inputs. The pending target, counters and state are registered.

Reset (rst=1 at a clock edge):
- state=BOOT, boot_cnt=0, stall_cnt=0, pend_target=0, stall_timeout=0.
- While in BOOT: pc_stall=1, pc_src=0, target_pc_addr=0, both flushes 0.

States:
- BOOT:
  - All inputs ignored; boot_cnt increments.
  - When boot_cnt==BOOT_CYCLES-1, go to RUN. First fetch advance happens BOOT_CYCLES cycles after rst deasserts.
- RUN, redirect selection:
  - ex_branch has priority over id_jump, since EX holds the older instruction.
  - ex_branch=1: target=ex_branch_target, if_id_flush=1, id_ex_flush=1.
  - Else id_jump=1: target=id_jump_target, if_id_flush=1, id_ex_flush=0.
- RUN, redirect and stall_req=0:
  - pc_src=1, pc_stall=0; stay in RUN. Zero-cycle latency: the PC loads the target at this edge.
- RUN, redirect and stall_req=1:
  - pc_stall=1, pc_src=0, flushes as above.
  - pend_target captures the selected target; go to PEND.
- RUN, no redirect:
  - pc_src=0, pc_stall=stall_req.
  - stall_req=1 → go to HOLD, stall_cnt=1.
- HOLD:
  - pc_stall=1, pc_src=0, flushes 0. Redirect inputs ignored (the stalled stages are not producing valid redirects).
  - stall_cnt increments, saturating at MAX_STALL.
  - stall_timeout is set when stall_cnt reaches MAX_STALL; only rst clears it.
  - stall_req=0 → pc_stall=0 in that same cycle, stall_cnt=0, go to RUN.
- PEND:
  - pc_stall=stall_req, target_pc_addr=pend_target, flushes 0.
  - New redirect inputs are ignored; they come from squashed slots.
  - stall_req=0 → pc_src=1 that cycle (PC loads pend_target), go to RUN.
  - stall_cnt counts and raises stall_timeout exactly as in HOLD.
- Simultaneous ex_branch and id_jump: EX wins; the ID jump is squashed by id_ex_flush/if_id_flush.
- rst mid-operation: any state returns to BOOT and the pending redirect is discarded.
- Target width: 30-bit word address; no arithmetic is performed and no wrap handling is needed.

Optional Feature:
- Macro: IF_FETCH_CTRL_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_redirects[31:0] (increments on each cycle pc_src=1) and perf_stall_cycles[31:0] (increments on each cycle pc_stall=1 outside BOOT).
  - Both counters wrap at 2^32 and clear on rst.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package: state encoding (BOOT=2'd0, RUN=2'd1, HOLD=2'd2, PEND=2'd3) and the 30-bit word-address width constant.
- One natural sub-module, if_fetch_ctrl_stall_timer: the saturating stall_cnt plus the sticky stall_timeout. All other logic stays flat.

Test Plan:
- Reset, BOOT_CYCLES=2: pulse rst, then idle inputs → pc_stall=1 for exactly 2 cycles after release, then 0; pc_src=0 throughout.
- RUN, ex_branch=1, ex_branch_target=30'h0000_0040, id_jump=1 in the same cycle → pc_src=1, target_pc_addr=0x40, both flushes 1, pc_stall=0, all for 1 cycle.
- RUN, id_jump=1, target 30'h10, mem_busy=1 for 3 cycles → first cycle: flush if_id only, pc_stall=1. Next 2 cycles: pc_stall=1, no flush. Cycle 4: pc_src=1, target=0x10.
- Load_use_stall held 1 cycle with no redirect → pc_stall=1 for one cycle; pc_src=0; no flushes; back to RUN.
- MAX_STALL=4, mem_busy held 6 cycles → stall_timeout rises on the 4th stall cycle and stays 1 after mem_busy drops, until rst.
- Assert rst while in PEND (pending target 0x20) → BOOT entered, and after boot pc_src stays 0 (the pending redirect is lost).
